// File: rtl/coax_pkg.sv
// Shared definitions for the 3270 coax transmit path: framing states,
// field sizes and the word parity helper.
package coax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    VIOLATION,
    SYNC,
    DATA,
    PARITY,
    END_SYNC,
    END_HOLD
  } state_t;

  localparam int QUIESCE_BITS = 5;
  localparam int DATA_BITS    = 10;

  // Even parity over data plus parity bit: parity equals XOR of the data.
  function automatic logic parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Single-clock FIFO with registered read data (one-cycle read latency).
// Writes while full and reads while empty are ignored.
module fifo_sync_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ena,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_ena && !full;
  assign do_rd = rd_ena && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coax_buffered_tx.sv
// FIFO-buffered 3270 coax transmitter: frames queued words into one message
// and drives a Manchester-encoded serial line.
module coax_buffered_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       load_strobe,
  output logic       full,
  output logic       empty,
  output logic       active,
  output logic       tx
);

  localparam int H  = CLOCKS_PER_BIT / 2;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_HALF  = CW'(H);
  localparam logic [CW-1:0] HOLD_LAST = CW'(H - 1);

  state_t                state, state_n;
  logic [CW-1:0]         clk_cnt, clk_n;
  logic [3:0]            bit_cnt, bit_n;
  logic                  rd_ena, rd_pend;
  logic [DATA_BITS-1:0]  rd_data, word;
  logic                  par_q, more_q, tx_n, last_clk;

  fifo_sync_ram #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .wr_ena  (load_strobe),
    .wr_data (data),
    .rd_ena  (rd_ena),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  function automatic logic manch(input logic b, input logic [CW-1:0] c);
    return (c < CLK_HALF) ? b : ~b;
  endfunction

  assign last_clk = (clk_cnt == CLK_LAST);

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    bit_n   = bit_cnt;
    rd_ena  = 1'b0;
    if (state != IDLE) begin
      clk_n = last_clk ? '0 : clk_cnt + 1'b1;
      if (last_clk && bit_cnt != '0) bit_n = bit_cnt - 4'd1;
    end
    case (state)
      IDLE: begin
        clk_n = '0;
        bit_n = '0;
        if (!empty) begin
          rd_ena  = 1'b1;
          state_n = QUIESCE;
          bit_n   = 4'(QUIESCE_BITS - 1);
        end
      end
      QUIESCE:   if (last_clk && bit_cnt == '0) begin state_n = VIOLATION; bit_n = 4'd2; end
      VIOLATION: if (last_clk && bit_cnt == '0) state_n = SYNC;
      SYNC:      if (last_clk && bit_cnt == '0) begin state_n = DATA; bit_n = 4'(DATA_BITS - 1); end
      DATA:      if (last_clk && bit_cnt == '0) state_n = PARITY;
      PARITY: begin
        rd_ena = (clk_cnt == '0) && !empty;
        if (last_clk) state_n = more_q ? SYNC : END_SYNC;
      end
      END_SYNC:  if (last_clk && bit_cnt == '0) begin state_n = END_HOLD; bit_n = 4'd1; end
      END_HOLD: begin
        if (bit_cnt == '0 && clk_cnt == HOLD_LAST) begin
          state_n = IDLE;
          clk_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line value is computed for the upcoming clock so tx stays aligned with state.
    tx_n = 1'b0;
    case (state_n)
      QUIESCE:   tx_n = manch(1'b1, clk_n);
      VIOLATION: tx_n = (bit_n == 4'd2) || (bit_n == 4'd1 && clk_n < CLK_HALF);
      SYNC:      tx_n = manch(1'b1, clk_n);
      DATA:      tx_n = manch(word[bit_n], clk_n);
      PARITY:    tx_n = manch(par_q, clk_n);
      END_SYNC:  tx_n = manch(1'b0, clk_n);
      END_HOLD:  tx_n = 1'b1;
      default:   tx_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      rd_pend <= 1'b0;
      word    <= '0;
      par_q   <= 1'b0;
      more_q  <= 1'b0;
      tx      <= 1'b0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_n;
      bit_cnt <= bit_n;
      rd_pend <= rd_ena;
      if (rd_pend) word <= rd_data;
      // Parity is frozen across PARITY because the next word lands mid-bit.
      if (state != PARITY) par_q <= parity(word);
      if (state == PARITY && clk_cnt == '0) more_q <= !empty;
      tx      <= tx_n;
      active  <= (state_n != IDLE);
    end
  end

endmodule
